edge_detect_multi: RTL and testbench

// - Multi-channel, parametrised successor to the single-line USB receiver edge detector.
// - Per channel: synchronises an asynchronous serial line, rejects glitches shorter than a

---
 rtl/edge_pkg.sv | 26 ++
 rtl/edge_chan.sv | 71 +++++++
 rtl/edge_detect_multi.sv | 44 ++++
 tb/tb_edge_detect_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
`timescale 1ns / 1ps

package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // True when an old->new level transition is one the selected mode reports.
  function automatic logic edge_match(edge_mode_t mode, logic old_lvl, logic new_lvl);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = ~old_lvl & new_lvl;
      EDGE_FALL: hit = old_lvl & ~new_lvl;
      EDGE_BOTH: hit = old_lvl ^ new_lvl;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One input line: synchroniser, glitch filter, registered edge pulse and sticky flag.
`timescale 1ns / 1ps

module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2,
  parameter logic        RST_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_in,
  input  logic [1:0] mode,
  input  logic       enable,
  input  logic       clear,
  output logic       d_filt,
  output logic       d_edge,
  output logic       edge_flag
);

  localparam int unsigned CntW = $clog2(FILT_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   edge_q, edge_d;
  logic                   flag_q, flag_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RST_LEVEL}};
      cnt_q  <= '0;
      filt_q <= RST_LEVEL;
      edge_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      edge_q <= edge_d;
      flag_q <= flag_d;
    end
  end

  // A differing level must persist FILT_LEN consecutive samples; any agreeing sample restarts.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    edge_d = 1'b0;
    if (sync_out != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync_out;
        edge_d = enable & edge_match(edge_mode_t'(mode), filt_q, sync_out);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A fresh edge wins over a simultaneous clear.
    flag_d = (flag_q & ~clear) | edge_d;
  end

  assign d_filt    = filt_q;
  assign d_edge    = edge_q;
  assign edge_flag = flag_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel filtered edge detector; one edge_chan per input line.
`timescale 1ns / 1ps

module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2,
  parameter logic        RST_LEVEL   = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] d_in,
  input  logic [1:0]        mode,
  input  logic              enable,
  input  logic              clear,
  output logic [NUM_CH-1:0] d_filt,
  output logic [NUM_CH-1:0] d_edge,
  output logic [NUM_CH-1:0] edge_flag,
  output logic              edge_any
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_LEVEL   (RST_LEVEL)
    ) u_chan (
      .clk       (clk),
      .n_rst     (n_rst),
      .d_in      (d_in[i]),
      .mode      (mode),
      .enable    (enable),
      .clear     (clear),
      .d_filt    (d_filt[i]),
      .d_edge    (d_edge[i]),
      .edge_flag (edge_flag[i])
    );
  end

  assign edge_any = |d_edge;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus random traffic against a history model.
`timescale 1ns / 1ps

module tb_edge_detect_multi;
  import edge_pkg::*;

  localparam int unsigned NumCh      = 4;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned FiltLen    = 2;

  logic             clk;
  logic             n_rst;
  logic [NumCh-1:0] d_in;
  logic [1:0]       mode;
  logic             enable;
  logic             clear;
  logic [NumCh-1:0] d_filt;
  logic [NumCh-1:0] d_edge;
  logic [NumCh-1:0] edge_flag;
  logic             edge_any;

  edge_detect_multi #(
    .NUM_CH      (NumCh),
    .SYNC_STAGES (SyncStages),
    .FILT_LEN    (FiltLen),
    .RST_LEVEL   (1'b1)
  ) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_in      (d_in),
    .mode      (mode),
    .enable    (enable),
    .clear     (clear),
    .d_filt    (d_filt),
    .d_edge    (d_edge),
    .edge_flag (edge_flag),
    .edge_any  (edge_any)
  );

  initial clk = 1'b0;
  always #1.25 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt [NumCh];

  // Reference: raw samples per posedge since reset; the filter accepts a new level once the
  // last FiltLen synchronised samples all disagree with the current filtered level.
  logic [NumCh-1:0] hist [$];
  logic [NumCh-1:0] m_filt, m_edge, m_flag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic mode_wants(logic [1:0] m, logic new_lvl);
    if (m == EDGE_BOTH) return 1'b1;
    if (m == EDGE_RISE) return new_lvl;
    if (m == EDGE_FALL) return !new_lvl;
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_filt = '1;
    m_edge = '0;
    m_flag = '0;
  endtask

  task automatic model_step();
    logic [NumCh-1:0] nf, ne;
    hist.push_back(d_in);
    nf = m_filt;
    ne = '0;
    for (int ch = 0; ch < NumCh; ch++) begin
      bit all_diff = 1'b1;
      for (int j = 0; j < FiltLen; j++) begin
        int  idx = hist.size() - 1 - SyncStages - j;
        logic v  = (idx < 0) ? 1'b1 : hist[idx][ch];
        if (v == m_filt[ch]) all_diff = 1'b0;
      end
      if (all_diff) begin
        nf[ch] = ~m_filt[ch];
        ne[ch] = enable && mode_wants(mode, nf[ch]);
      end
    end
    m_flag = (clear ? '0 : m_flag) | ne;
    m_edge = ne;
    m_filt = nf;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("d_filt", 32'(d_filt), 32'(m_filt));
    check_eq("d_edge", 32'(d_edge), 32'(m_edge));
    check_eq("edge_flag", 32'(edge_flag), 32'(m_flag));
    check_eq("edge_any", 32'(edge_any), 32'(|m_edge));
    for (int ch = 0; ch < NumCh; ch++) edge_cnt[ch] += int'(d_edge[ch]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clr_cnt();
    for (int ch = 0; ch < NumCh; ch++) edge_cnt[ch] = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_filt"}, 32'(d_filt), 32'hF);
    check_eq({tag, "_edge"}, 32'(d_edge), 32'h0);
    check_eq({tag, "_flag"}, 32'(edge_flag), 32'h0);
    check_eq({tag, "_any"}, 32'(edge_any), 32'h0);
  endtask

  // Asserts reset between edges, checks outputs at once, releases after a negedge.
  task automatic async_reset(input string tag);
    #0.4 n_rst = 1'b0;
    model_reset();
    #0.2 check_reset_vals(tag);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst  = 1'b0;
    d_in   = 4'h0;
    mode   = EDGE_BOTH;
    enable = 1'b1;
    clear  = 1'b0;
    model_reset();
    clr_cnt();

    // 1. Reset with lines low, then every line produces an edge at the fourth posedge.
    #5 check_reset_vals("rst");
    @(negedge clk);
    n_rst = 1'b1;
    run(3);
    check_eq("t1_no_early_edge", 32'(d_edge), 32'h0);
    run(1);
    check_eq("t1_edge4", 32'(d_edge), 32'hF);
    check_eq("t1_filt4", 32'(d_filt), 32'h0);
    run(3);

    // 2. Clean falling edge on ch0 in FALL mode; the return rise gives nothing.
    mode = EDGE_FALL;
    d_in = 4'hF;
    run(6);
    clr_cnt();
    d_in[0] = 1'b0;
    run(6);
    check_eq("t2_fall_pulse", 32'(edge_cnt[0]), 32'd1);
    d_in[0] = 1'b1;
    run(6);
    check_eq("t2_rise_silent", 32'(edge_cnt[0]), 32'd1);

    // 3. Glitch rejection on ch1.
    clr_cnt();
    d_in[1] = 1'b0;
    run(1);
    d_in[1] = 1'b1;
    run(6);
    check_eq("t3_glitch1", 32'(edge_cnt[1]), 32'd0);
    d_in[1] = 1'b0;
    run(2);
    d_in[1] = 1'b1;
    run(6);
    check_eq("t3_glitch2", 32'(edge_cnt[1]), 32'd1);
    clr_cnt();
    for (int k = 0; k < 10; k++) begin
      d_in[1] = ~d_in[1];
      run(1);
    end
    d_in[1] = 1'b1;
    run(6);
    check_eq("t3_alternate", 32'(edge_cnt[1]), 32'd0);

    // 4. Modes on ch2: two low/high pulses per mode setting.
    for (int m = 0; m < 4; m++) begin
      logic [1:0] mv [4] = '{EDGE_RISE, EDGE_BOTH, EDGE_OFF, EDGE_BOTH};
      int         ex [4] = '{2, 4, 0, 0};
      mode   = mv[m];
      enable = (m != 3);
      clr_cnt();
      repeat (2) begin
        d_in[2] = 1'b0;
        run(4);
        d_in[2] = 1'b1;
        run(4);
      end
      run(2);
      check_eq("t4_mode_pulses", 32'(edge_cnt[2]), 32'(ex[m]));
    end
    check_eq("t4_flag_hold", 32'(edge_flag[2]), 32'd1);
    enable = 1'b1;

    // 5. Sticky flag on ch3 with clear colliding with an accepted edge.
    mode  = EDGE_BOTH;
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    d_in[3] = 1'b0;
    run(6);
    check_eq("t5_flag_set", 32'(edge_flag[3]), 32'd1);
    d_in[3] = 1'b1;
    run(3);
    clear = 1'b1;
    run(1);
    check_eq("t5_edge_beats_clear", 32'(edge_flag[3]), 32'd1);
    clear = 1'b0;
    run(2);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    check_eq("t5_clear_alone", 32'(edge_flag[3]), 32'd0);

    // 6. Reset while ch0 is half way through its filter.
    d_in[0] = 1'b0;
    run(3);
    d_in = 4'hF;
    async_reset("t6_rst");
    clr_cnt();
    run(8);
    check_eq("t6_no_edge", 32'(edge_any | (|edge_cnt[0]) | (|edge_cnt[1])
                                | (|edge_cnt[2]) | (|edge_cnt[3])), 32'd0);

    // Random traffic: lines flip occasionally, controls wander, rare async resets.
    for (int k = 0; k < 1500; k++) begin
      for (int ch = 0; ch < NumCh; ch++)
        if ($urandom_range(3) == 0) d_in[ch] = ~d_in[ch];
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      enable = ($urandom_range(9) != 0);
      clear  = ($urandom_range(9) == 0);
      if ($urandom_range(399) == 0) async_reset("rnd_rst");
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
